dmem_sram_resp: RTL and testbench

- Data-memory responder on the M-stage data port, sitting on the memory side of the CPU's byte-lane load/store selector.
- Accepts word-aligned requests: 4-bit byte strobe, replicated write data, full 32-bit address.
- Commits byte-masked writes into an on-chip word array.
- Returns full 32-bit read words after a configurable latency; the CPU-side selector extracts and extends the lanes.

---
 rtl/dmem_sram_resp.sv | 171 +++++++++++++++++
 tb/tb_dmem_sram_resp.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dmem_sram_resp.sv
// Data-memory responder: byte-masked word SRAM with fixed-latency single-outstanding response.
// Optional out-of-range error reporting is enabled by defining DMEM_ERR_EN.
module dmem_sram_resp #(
    parameter int AW      = 16,
    parameter int LATENCY = 1,
    parameter int BASE_HI = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
`ifdef DMEM_ERR_EN
    output logic        err,
`endif
    output logic [31:0] rdata
);

    localparam int DEPTH = 1 << (AW - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_nx_s;
    logic          data_ok_r;
    logic [31:0]   rdata_r;
    logic [31:0]   rd_hold_r;
    logic          wr_r;
    logic          oor_r;
    logic          err_r;
    logic          addr_ok_s;
    logic          accept_s;
    logic          oor_s;
    logic          resp_oor_s;
    logic [31:0]   resp_data_s;
    logic [31:0]   mem_rd_s;
    logic [AW-3:0] idx_s;
    logic [31:0]   mem_r [DEPTH];

    assign idx_s    = addr[AW-1:2];
    assign mem_rd_s = mem_r[idx_s];

`ifdef DMEM_ERR_EN
    logic unused_s;
    assign unused_s = ^addr[1:0];
    assign oor_s    = (addr[31:AW] != BASE_HI[31-AW:0]) ? 1'b1 : 1'b0;
    assign err      = err_r;
`else
    logic unused_s;
    assign unused_s = ^{addr[31:AW], addr[1:0], 32'(BASE_HI), err_r};
    assign oor_s    = 1'b0;
`endif

    // Handshake, next-state and the word that will be presented when entering RESP.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        addr_ok_s   = 1'b0;
        resp_oor_s  = oor_r;
        resp_data_s = 32'h0000_0000;

        if (state_r != S_WAIT) begin
            addr_ok_s = 1'b1;
        end else begin
            addr_ok_s = 1'b0;
        end
        accept_s = req & addr_ok_s;

        case (state_r)
            S_IDLE, S_RESP: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        state_nx_s = S_RESP;
                        cnt_nx_s   = 4'd0;
                    end else begin
                        state_nx_s = S_WAIT;
                        cnt_nx_s   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_nx_s = S_IDLE;
                    cnt_nx_s   = 4'd0;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nx_s = S_RESP;
                    cnt_nx_s   = 4'd0;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase

        // With LATENCY == 1 the response is formed straight from the array at acceptance.
        if (accept_s) begin
            resp_oor_s = oor_s;
            if (wr | oor_s) begin
                resp_data_s = 32'h0000_0000;
            end else begin
                resp_data_s = mem_rd_s;
            end
        end else begin
            resp_oor_s = oor_r;
            if (wr_r | oor_r) begin
                resp_data_s = 32'h0000_0000;
            end else begin
                resp_data_s = rd_hold_r;
            end
        end
    end

    // Byte-masked array write at acceptance; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (accept_s && wr && !oor_s && wstrb[i]) begin
                mem_r[idx_s][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Control state, captured request attributes and registered response outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= S_IDLE;
            cnt_r     <= 4'd0;
            data_ok_r <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rd_hold_r <= 32'h0000_0000;
            wr_r      <= 1'b0;
            oor_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (accept_s) begin
                wr_r  <= wr;
                oor_r <= oor_s;
                if (!wr) begin
                    rd_hold_r <= mem_rd_s;
                end
            end
            if (state_nx_s == S_RESP) begin
                data_ok_r <= 1'b1;
                rdata_r   <= resp_data_s;
                err_r     <= resp_oor_s;
            end else begin
                data_ok_r <= 1'b0;
                err_r     <= 1'b0;
            end
        end
    end

    assign addr_ok = addr_ok_s;
    assign data_ok = data_ok_r;
    assign rdata   = rdata_r;

endmodule

// File: tb/tb_dmem_sram_resp.sv
// Directed bench: LATENCY=1 and LATENCY=3 instances checked with immediate assertions.
module tb_dmem_sram_resp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req1, wr1, req3, wr3;
    logic [3:0]  wstrb1, wstrb3;
    logic [31:0] addr1, wdata1, addr3, wdata3;
    logic        addr_ok1, data_ok1, addr_ok3, data_ok3;
    logic [31:0] rdata1, rdata3;
`ifdef DMEM_ERR_EN
    logic        err1, err3;
`endif
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dmem_sram_resp #(.AW(16), .LATENCY(1), .BASE_HI(0)) u1 (
        .clk(clk), .resetn(resetn), .req(req1), .wr(wr1), .wstrb(wstrb1),
        .addr(addr1), .wdata(wdata1), .addr_ok(addr_ok1), .data_ok(data_ok1),
`ifdef DMEM_ERR_EN
        .err(err1),
`endif
        .rdata(rdata1)
    );

    dmem_sram_resp #(.AW(16), .LATENCY(3), .BASE_HI(0)) u3 (
        .clk(clk), .resetn(resetn), .req(req3), .wr(wr3), .wstrb(wstrb3),
        .addr(addr3), .wdata(wdata3), .addr_ok(addr_ok3), .data_ok(data_ok3),
`ifdef DMEM_ERR_EN
        .err(err3),
`endif
        .rdata(rdata3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with u1 in IDLE or RESP; checks the response one cycle later.
    task automatic op1(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag);
        req1 = 1'b1; wr1 = w; wstrb1 = s; addr1 = a; wdata1 = d;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_data_ok"}, data_ok1, 32'd1);
        chk({tag, "_rdata"}, rdata1, exp_rd);
`ifdef DMEM_ERR_EN
        chk({tag, "_err"}, err1, {31'd0, exp_err});
`else
        if (exp_err) $error("FAIL %s err expected but feature absent", tag);
`endif
        req1 = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        req1 = 1'b0; wr1 = 1'b0; wstrb1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;
        req3 = 1'b0; wr3 = 1'b0; wstrb3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
        @(negedge clk);
        chk("rst_addr_ok1", addr_ok1, 32'd1);
        chk("rst_data_ok1", data_ok1, 32'd0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_addr_ok3", addr_ok3, 32'd1);
        chk("rst_data_ok3", data_ok3, 32'd0);
        chk("rst_rdata3", rdata3, 32'h0);
        resetn = 1'b1;

        // LATENCY=1: full write, readback, lane merges and empty strobe
        op1(1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0, 1'b0, "l1_wr");
        op1(1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1122_3344, 1'b0, "l1_rd");
        op1(1'b1, 4'h4, 32'h0000_0010, 32'hAAAA_AAAA, 32'h0, 1'b0, "merge_b2");
        op1(1'b1, 4'h3, 32'h0000_0010, 32'h5566_5566, 32'h0, 1'b0, "merge_h0");
        op1(1'b0, 4'h0, 32'h0000_0012, 32'h0, 32'h11AA_5566, 1'b0, "merge_rd");
        op1(1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0, 1'b0, "strb0_wr");
        op1(1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h11AA_5566, 1'b0, "strb0_rd");
        @(negedge clk);
        chk("idle_data_ok1", data_ok1, 32'd0);
        chk("idle_rdata_hold1", rdata1, 32'h11AA_5566);
        chk("idle_addr_ok1", addr_ok1, 32'd1);
`ifdef DMEM_ERR_EN
        op1(1'b1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF, 32'h0, 1'b1, "oor_wr");
        op1(1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h11AA_5566, 1'b0, "oor_rd");
`else
        op1(1'b1, 4'hF, 32'h0001_0020, 32'hCAFE_F00D, 32'h0, 1'b0, "alias_wr");
        op1(1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, "alias_rd");
`endif

        // LATENCY=3: write, back-to-back read from RESP, then reset during WAIT
        @(negedge clk);
        req3 = 1'b1; wr3 = 1'b1; wstrb3 = 4'hF; addr3 = 32'h0000_0040; wdata3 = 32'h0102_0304;
        @(posedge clk); @(negedge clk);
        chk("l3_w0_addr_ok", addr_ok3, 32'd0);
        chk("l3_w0_data_ok", data_ok3, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("l3_w1_addr_ok", addr_ok3, 32'd0);
        chk("l3_w1_data_ok", data_ok3, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("l3_wr_data_ok", data_ok3, 32'd1);
        chk("l3_wr_addr_ok", addr_ok3, 32'd1);
        chk("l3_wr_rdata", rdata3, 32'h0);
        wr3 = 1'b0; wstrb3 = 4'h0; wdata3 = 32'h0;
        @(posedge clk); @(negedge clk);
        chk("l3_r0_addr_ok", addr_ok3, 32'd0);
        chk("l3_r0_data_ok", data_ok3, 32'd0);
        req3 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("l3_r1_addr_ok", addr_ok3, 32'd0);
        chk("l3_r1_data_ok", data_ok3, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("l3_rd_data_ok", data_ok3, 32'd1);
        chk("l3_rd_rdata", rdata3, 32'h0102_0304);
        req3 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("l3_r2_addr_ok", addr_ok3, 32'd0);
        req3 = 1'b0;
        @(posedge clk); @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("l3_rst_data_ok", data_ok3, 32'd0);
        chk("l3_rst_rdata", rdata3, 32'h0);
        chk("l3_rst_addr_ok", addr_ok3, 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("l3_rel_addr_ok", addr_ok3, 32'd1);
        chk("l3_rel_data_ok", data_ok3, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("l3_no_pulse", data_ok3, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
